// File: rtl/cpu_constant.sv
// cpu_constant: constants shared by the multi-cycle controller and its helpers.
//   - register-file control encodings (RF_RRD / RF_RWT)
//   - major opcodes, ALU operation codes
//   - controller state encoding
//   - alu_decode(): funct3/funct7 -> alu_op mapping
package cpu_constant;

  // rf_ctl[0] meaning when rf_ctl[1] (enable) is set
  localparam logic RF_RRD = 1'b0;
  localparam logic RF_RWT = 1'b1;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_ECALL = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  // Loads/stores use ADD for address generation; branches compare via SUB.
  function automatic logic [3:0] alu_decode(input logic [6:0] opcode,
                                            input logic [2:0] funct3,
                                            input logic       funct7_b5);
    logic [3:0] op;
    op = ALU_ADD;
    if (opcode == OP_BR) begin
      op = ALU_SUB;
    end else if (opcode == OP_R || opcode == OP_I) begin
      case (funct3)
        3'b000:  op = (opcode == OP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
        3'b001:  op = ALU_SLL;
        3'b010:  op = ALU_SLT;
        3'b011:  op = ALU_SLTU;
        3'b100:  op = ALU_XOR;
        3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
        3'b110:  op = ALU_OR;
        default: op = ALU_AND;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/mc_imm_gen.sv
// mc_imm_gen: combinational immediate decoder.
//   ir  in  32  instruction register
//   imm out 32  sign-extended immediate (S for stores, B for branches, I otherwise)
module mc_imm_gen
  import cpu_constant::*;
(
  input  logic [31:0] ir,
  output logic [31:0] imm
);

  // rs1/funct3 field never contributes to I/S/B immediates
  logic unused_ir;
  assign unused_ir = ^ir[19:12];

  always_comb begin
    imm = {{20{ir[31]}}, ir[31:20]};
    case (ir[6:0])
      OP_SW:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BR:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default: imm = {{20{ir[31]}}, ir[31:20]};
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle fetch/decode/exec/mem/wb sequencer in front of the register file.
//   clk, rst (sync, active-high)
//   imem_req/imem_addr/imem_rdata/imem_ready : instruction fetch handshake
//   dmem_req/dmem_we/dmem_ready              : data access handshake
//   rs1/rs2/rd, rf_ctl                        : register file indices and control
//   alu_op, alu_src_imm, imm, ans_sel         : datapath controls
//   zero, neg                                 : register file flags on Ans
//   pc, halt                                  : architectural PC, sticky halt
//   cycle_cnt, instret_cnt                    : perf counters, built only with MC_PERF_CNT_EN
module mc_control
  import cpu_constant::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [1:0]  rf_ctl,
  output logic [3:0]  alu_op,
  output logic        alu_src_imm,
  output logic [31:0] imm,
  output logic        ans_sel,
  input  logic        zero,
  input  logic        neg,
  output logic [31:0] pc,
  output logic        halt,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        use_imm;
  logic        br_taken;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign rs1       = ir_q[19:15];
  assign rs2       = ir_q[24:20];
  assign rd        = ir_q[11:7];
  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign use_imm   = (opcode == OP_I) || (opcode == OP_LW) || (opcode == OP_SW);

  mc_imm_gen u_imm_gen (
    .ir  (ir_q),
    .imm (imm)
  );

  // Flags come from a-b computed in EXEC; overflow is deliberately ignored.
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:          br_taken = zero;
      3'b001:          br_taken = !zero;
      3'b100, 3'b110:  br_taken = neg;
      3'b101, 3'b111:  br_taken = !neg;
      default:         br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_ctl      = 2'b00;
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    ans_sel     = 1'b0;
    halt        = 1'b0;

    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        rf_ctl = {1'b1, RF_RRD};
        if (opcode == OP_R || opcode == OP_I || opcode == OP_LW ||
            opcode == OP_SW || opcode == OP_BR) begin
          state_d = EXEC;
        end else begin
          state_d = HALT;
        end
      end
      EXEC: begin
        alu_op      = alu_decode(opcode, funct3, ir_q[30]);
        alu_src_imm = use_imm;
        if (opcode == OP_BR) begin
          pc_d    = br_taken ? (pc_q + imm) : (pc_q + 32'd4);
          state_d = FETCH;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        // Keep ALU controls steady so the address stays stable through wait states.
        alu_op      = alu_decode(opcode, funct3, ir_q[30]);
        alu_src_imm = use_imm;
        dmem_req    = 1'b1;
        dmem_we     = (opcode == OP_SW);
        if (dmem_ready) begin
          if (opcode == OP_SW) begin
            pc_d    = pc_q + 32'd4;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        alu_op      = alu_decode(opcode, funct3, ir_q[30]);
        alu_src_imm = use_imm;
        rf_ctl      = {(rd != 5'd0), RF_RWT};
        ans_sel     = (opcode == OP_LW);
        pc_d        = pc_q + 32'd4;
        state_d     = FETCH;
      end
      HALT: begin
        halt = 1'b1;
      end
      default: begin
        state_d = HALT;
      end
    endcase

    // While reset is held every request/control output reads as idle.
    if (rst) begin
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      rf_ctl      = 2'b00;
      alu_op      = ALU_ADD;
      alu_src_imm = 1'b0;
      ans_sel     = 1'b0;
      halt        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_q, instret_q;
  logic        retire;

  // An instruction retires on any return to FETCH from a later stage.
  assign retire = (state_d == FETCH) &&
                  ((state_q == EXEC) || (state_q == MEM) || (state_q == WB));

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      if (state_q != HALT) cycle_q <= cycle_q + 32'd1;
      if (retire)          instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = 32'd0;
  assign instret_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;
  import cpu_constant::*;

`ifdef MC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [31:0] I_ADDI = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] I_LW   = 32'h0080_A103;  // lw   x2,8(x1)
  localparam logic [31:0] I_ADD0 = 32'h0020_8033;  // add  x0,x1,x2
  localparam logic [31:0] I_SUB  = 32'h4020_81B3;  // sub  x3,x1,x2
  localparam logic [31:0] I_BEQM = 32'hFE10_8CE3;  // beq  x1,x1,-8
  localparam logic [31:0] I_BEQP = 32'h0010_8463;  // beq  x1,x1,+8
  localparam logic [31:0] I_BLT  = 32'h0020_C663;  // blt  x1,x2,+12
  localparam logic [31:0] I_BGE  = 32'h0020_D663;  // bge  x1,x2,+12
  localparam logic [31:0] I_SW   = 32'h0020_A223;  // sw   x2,4(x1)

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [4:0]  rs1, rs2, rd;
  logic [1:0]  rf_ctl;
  logic [3:0]  alu_op;
  logic        alu_src_imm, ans_sel, zero, neg, halt;
  logic [31:0] imm, pc, cycle_cnt, instret_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mc_control dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ready  (dmem_ready),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .rf_ctl      (rf_ctl),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .imm         (imm),
    .ans_sel     (ans_sel),
    .zero        (zero),
    .neg         (neg),
    .pc          (pc),
    .halt        (halt),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present instr in FETCH with no wait state; returns in DECODE.
  task automatic fetch(input logic [31:0] instr);
    imem_rdata = instr;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
  endtask

  // Branch: FETCH, DECODE, EXEC then back in FETCH at the resolved pc.
  task automatic run_branch(input string tag, input logic [31:0] instr, input logic z,
                            input logic n, input logic [31:0] exp_pc);
    fetch(instr);
    chk({tag, "_dec_rfctl"}, {30'd0, rf_ctl}, 32'd2);
    step();
    zero = z;
    neg  = n;
    #1;
    chk({tag, "_exe_rfctl"}, {30'd0, rf_ctl}, 32'd0);
    chk({tag, "_exe_aluop"}, {28'd0, alu_op}, {28'd0, ALU_SUB});
    step();
    chk({tag, "_pc"}, pc, exp_pc);
    zero = 1'b0;
    neg  = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = 32'h0000_0013;
    dmem_ready = 1'b0;
    zero       = 1'b0;
    neg        = 1'b0;
    step();
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_rf_ctl", {30'd0, rf_ctl}, 32'd0);
    chk("rst_rd", {27'd0, rd}, 32'd0);
    chk("rst_cycle", cycle_cnt, 32'd0);

    // addi x1,x0,5
    rst = 1'b0;
    imem_rdata = I_ADDI;
    imem_ready = 1'b1;
    #1;
    chk("addi_f_req", {31'd0, imem_req}, 32'd1);
    chk("addi_f_addr", imem_addr, 32'h0);
    step();
    imem_ready = 1'b0;
    chk("addi_d_rfctl", {30'd0, rf_ctl}, 32'd2);
    chk("addi_d_req", {31'd0, imem_req}, 32'd0);
    step();
    chk("addi_e_src", {31'd0, alu_src_imm}, 32'd1);
    chk("addi_e_rfctl", {30'd0, rf_ctl}, 32'd0);
    step();
    chk("addi_wb_rfctl", {30'd0, rf_ctl}, 32'd3);
    chk("addi_wb_rd", {27'd0, rd}, 32'd1);
    chk("addi_wb_src", {31'd0, alu_src_imm}, 32'd1);
    chk("addi_wb_imm", imm, 32'd5);
    chk("addi_wb_anssel", {31'd0, ans_sel}, 32'd0);
    step();
    chk("addi_pc", pc, 32'h4);
    chk("addi_cycle", cycle_cnt, PERF ? 32'd4 : 32'd0);
    chk("addi_instret", instret_cnt, PERF ? 32'd1 : 32'd0);

    // lw x2,8(x1) with three data wait states
    fetch(I_LW);
    step();
    chk("lw_e_src", {31'd0, alu_src_imm}, 32'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("lw_m_req", {31'd0, dmem_req}, 32'd1);
      chk("lw_m_we", {31'd0, dmem_we}, 32'd0);
      step();
    end
    dmem_ready = 1'b1;
    #1;
    chk("lw_m_req4", {31'd0, dmem_req}, 32'd1);
    step();
    dmem_ready = 1'b0;
    chk("lw_wb_req", {31'd0, dmem_req}, 32'd0);
    chk("lw_wb_anssel", {31'd0, ans_sel}, 32'd1);
    chk("lw_wb_rfctl", {30'd0, rf_ctl}, 32'd3);
    chk("lw_wb_rd", {27'd0, rd}, 32'd2);
    step();
    chk("lw_pc", pc, 32'h8);
    chk("lw_cycle", cycle_cnt, PERF ? 32'd12 : 32'd0);
    chk("lw_instret", instret_cnt, PERF ? 32'd2 : 32'd0);

    // add x0,x1,x2 after one fetch wait state
    imem_rdata = I_ADD0;
    imem_ready = 1'b0;
    step();
    chk("fwait_req", {31'd0, imem_req}, 32'd1);
    chk("fwait_pc", pc, 32'h8);
    chk("fwait_rfctl", {30'd0, rf_ctl}, 32'd0);
    fetch(I_ADD0);
    step();
    chk("add0_e_src", {31'd0, alu_src_imm}, 32'd0);
    step();
    chk("add0_wb_rfctl", {30'd0, rf_ctl}, 32'd1);
    step();
    chk("add0_pc", pc, 32'hC);

    // sub x3,x1,x2
    fetch(I_SUB);
    step();
    chk("sub_e_aluop", {28'd0, alu_op}, {28'd0, ALU_SUB});
    step();
    chk("sub_wb_rd", {27'd0, rd}, 32'd3);
    step();
    chk("sub_pc", pc, 32'h10);

    // branches
    fetch(I_BEQM);
    chk("beqm_imm", imm, 32'hFFFF_FFF8);
    step();
    zero = 1'b1;
    #1;
    chk("beqm_e_rfctl", {30'd0, rf_ctl}, 32'd0);
    step();
    zero = 1'b0;
    chk("beqm_taken_pc", pc, 32'h8);
    run_branch("beqp", I_BEQP, 1'b1, 1'b0, 32'h10);
    run_branch("beqm_nt", I_BEQM, 1'b0, 1'b0, 32'h14);
    run_branch("blt_t", I_BLT, 1'b0, 1'b1, 32'h20);
    run_branch("bge_nt", I_BGE, 1'b0, 1'b1, 32'h24);

    // sw x2,4(x1), no wait state
    fetch(I_SW);
    chk("sw_imm", imm, 32'd4);
    step();
    step();
    dmem_ready = 1'b1;
    #1;
    chk("sw_m_req", {31'd0, dmem_req}, 32'd1);
    chk("sw_m_we", {31'd0, dmem_we}, 32'd1);
    step();
    dmem_ready = 1'b0;
    chk("sw_pc", pc, 32'h28);
    chk("sw_fetch_req", {31'd0, imem_req}, 32'd1);

    // sw interrupted by reset during a wait state
    fetch(I_SW);
    step();
    step();
    chk("swr_m_req", {31'd0, dmem_req}, 32'd1);
    step();
    chk("swr_m_req_wait", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1;
    step();
    chk("swr_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("swr_pc", pc, 32'h0);
    chk("swr_cycle", cycle_cnt, 32'd0);
    chk("swr_instret", instret_cnt, 32'd0);
    rst = 1'b0;
    #1;
    chk("swr_fetch_req", {31'd0, imem_req}, 32'd1);
    chk("swr_fetch_addr", imem_addr, 32'h0);

    // illegal opcode halts
    fetch(32'hFFFF_FFFF);
    chk("ill_d_halt", {31'd0, halt}, 32'd0);
    step();
    chk("ill_halt", {31'd0, halt}, 32'd1);
    chk("ill_rfctl", {30'd0, rf_ctl}, 32'd0);
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ill_req", {31'd0, imem_req}, 32'd0);
      chk("ill_sticky", {31'd0, halt}, 32'd1);
      chk("ill_pc", pc, 32'h0);
    end
    chk("ill_cycle", cycle_cnt, PERF ? 32'd2 : 32'd0);
    chk("ill_instret", instret_cnt, 32'd0);
    imem_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("post_halt", {31'd0, halt}, 32'd0);
    chk("post_req", {31'd0, imem_req}, 32'd1);
    chk("post_pc", pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle sequencer sitting directly upstream of the register file. It fetches an instruction, decodes it, and drives the register file's rs1/rs2/rd and 2-bit ctl.
- It also sequences the ALU and data-memory phases, and updates the PC using the flags returned by the register file.
- Owns the PC and the instruction register (IR).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, IR value on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address (= pc).
- imem_rdata  in  32  fetched instruction.
- imem_ready  in  1  fetch data valid.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_ready  in  1  data access complete.
- rs1, rs2, rd  out  5 each  register indices, taken from IR[19:15], IR[24:20], IR[11:7].
- rf_ctl  out  2  register-file control: bit1 = enable, bit0 = RF_RRD (0) or RF_RWT (1).
- alu_op  out  4  ALU operation code.
- alu_src_imm  out  1  ALU operand B is imm rather than b.
- imm  out  32  sign-extended immediate.
- ans_sel  out  1  write-back source: 0 = ALU, 1 = load data.
- zero, neg  in  1 each  flags from the register file, computed on Ans.
- pc  out  32  current PC.
- halt  out  1  sticky halt indicator.
- cycle_cnt, instret_cnt  out  32 each  performance counters (see Optional Feature).

Behaviour:
- Reset, applied synchronously on any cycle including mid-access:
  - state = FETCH, pc = RESET_PC, IR = NOP_INSTR, halt = 0.
  - All request, control and select outputs are 0; rf_ctl = 2'b00.
  - An outstanding imem_req or dmem_req drops the cycle after rst is sampled high.
- Handshake rules (same for both memory ports):
  - req is held high with address stable until ready is sampled high.
  - The transfer completes on the edge where req & ready.
  - ready is ignored while req is low.
- FETCH:
  - imem_req = 1.
  - On imem_ready: IR <= imem_rdata, go to DECODE.
  - Otherwise remain in FETCH (wait states are unbounded).
- DECODE:
  - rf_ctl = {1, RF_RRD}, so the register file latches a and b.
  - imm is decoded from IR by format: I, S or B.
  - Opcode dispatch:
    - 0110011 (R-type), 0010011 (I-type ALU), 0000011 (LW), 0100011 (SW), 1100011 (branch): go to EXEC.
    - 1110011 (ecall) or any other opcode: go to HALT.
- EXEC:
  - alu_op is driven from funct3/funct7; alu_src_imm = 1 for I, LW and SW.
  - Branches compute a-b and resolve in this cycle:
    - BEQ taken if zero; BNE if !zero; BLT if neg; BGE if !neg. Overflow is ignored.
    - pc <= taken ? pc+imm : pc+4, then go to FETCH.
  - LW and SW go to MEM; R-type and I-type go to WB.
- MEM:
  - dmem_req = 1; dmem_we = 1 for SW.
  - On dmem_ready: SW sets pc <= pc+4 and goes to FETCH; LW goes to WB.
- WB:
  - rf_ctl = {rd != 0, RF_RWT}; x0 is never written.
  - ans_sel = 1 for LW.
  - pc <= pc+4, go to FETCH.
- HALT:
  - halt = 1; no requests issued; rf_ctl = 00.
  - Left only by reset.
- Latency with zero wait states: R/I 4 cycles, LW 5, SW 4, branch 3.
- PC arithmetic is modulo 2^32; wrap-around at 32'hFFFF_FFFC -> 0 is legal.
- Misaligned PC is not checked.
- rf_ctl[1] is 0 in every state other than DECODE and WB.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- When defined:
  - cycle_cnt increments every cycle in which state != HALT.
  - instret_cnt increments on each FETCH entry that follows a completed instruction.
  - Both clear on rst and wrap modulo 2^32.
- When undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Shared package cpu_constant holds:
  - RF_RRD and RF_RWT.
  - Opcode constants.
  - alu_op codes.
  - State encoding: FETCH, DECODE, EXEC, MEM, WB, HALT.
- One sub-module, mc_imm_gen: combinational IR -> imm for the I, S and B formats.

Test Plan:
- Reset, then `addi x1,x0,5` with imem_ready=1:
  - FETCH/DECODE/EXEC/WB in 4 cycles.
  - WB shows rf_ctl=2'b11, rd=1, alu_src_imm=1, imm=5; pc=4.
- `lw x2,8(x1)` with dmem_ready delayed 3 cycles:
  - dmem_req stays high 4 cycles; dmem_we=0; ans_sel=1 in WB; 8 cycles total.
- `beq x1,x1,-8` at pc=0x10 with zero=1:
  - pc=0x08 after 3 cycles; rf_ctl never equals 2'b11.
  - Repeat with zero=0: pc=0x14.
- `add x0,x1,x2`:
  - WB shows rf_ctl=2'b01 (write suppressed); pc advances by 4.
- Illegal opcode 32'hFFFF_FFFF:
  - halt=1 after DECODE; no imem_req thereafter.
  - rst clears halt and restarts fetch at RESET_PC.
- rst asserted during an SW wait state:
  - dmem_req=0 the next cycle; pc=RESET_PC.
  - With MC_PERF_CNT_EN: cycle_cnt=0 and instret_cnt=0.
